// File: rtl/usb_ep_tx_sched.sv
// -----------------------------------------------------------------------------
// usb_ep_tx_sched
//
// Shares the USB device controller's single IN (tx) data interface between
// NUM_SRC first-word-fall-through byte FIFOs (e.g. ADC stream, CDC echo).
// While idle, it decodes the endpoint the controller is addressing and
// publishes the registered packet length and cork flag for that source. When
// the controller starts an IN transfer, the source is locked for the whole
// packet. Pops and data are routed to and from that source, and popped bytes
// are counted. A one-cycle completion report follows the packet.
//
// Optional feature macro: USB_TX_ZLP_EN
//   When defined, a source whose last packet was exactly MAX_PKT bytes and
//   that now has no data offers a zero-length packet instead of corking, so
//   the host sees the end of the transfer.
//
// Ports
//   clk_i        PHY clock (60 MHz)
//   reset_i      asynchronous active-high reset
//   usbrst_i     USB bus reset, synchronous abort
//   endpt_i      endpoint addressed by the controller
//   txact_i      controller IN transfer active
//   txpop_i      controller consumes txdat_o this cycle
//   txpktfin_i   controller packet-finished pulse
//   txdat_o      byte to controller (combinational from locked source)
//   txval_o      txdat_o valid
//   txdat_len_o  payload length of the next packet
//   txcork_o     1 = nothing to send, controller NAKs
//   src_dat_i    FWFT head byte per source, packed 8 bits per source
//   src_val_i    head valid per source
//   src_cnt_i    bytes available per source, packed LEN_W bits per source
//   src_pop_o    pop strobe per source (one-hot or zero)
//   pkt_done_o   one-cycle pulse at the end of each locked packet
//   pkt_src_o    source index of the finished packet
//   pkt_bytes_o  bytes popped in the finished packet
//   overrun_o    sticky: controller popped beyond the latched length
// -----------------------------------------------------------------------------
module usb_ep_tx_sched #(
  parameter int unsigned          NUM_SRC = 2,
  parameter logic [4*NUM_SRC-1:0] EP_MAP  = 8'h32,
  parameter int unsigned          MAX_PKT = 512,
  parameter int unsigned          LEN_W   = 12
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     usbrst_i,
  input  logic [3:0]               endpt_i,
  input  logic                     txact_i,
  input  logic                     txpop_i,
  input  logic                     txpktfin_i,
  output logic [7:0]               txdat_o,
  output logic                     txval_o,
  output logic [LEN_W-1:0]         txdat_len_o,
  output logic                     txcork_o,
  input  logic [8*NUM_SRC-1:0]     src_dat_i,
  input  logic [NUM_SRC-1:0]       src_val_i,
  input  logic [LEN_W*NUM_SRC-1:0] src_cnt_i,
  output logic [NUM_SRC-1:0]       src_pop_o,
  output logic                     pkt_done_o,
  output logic [2:0]               pkt_src_o,
  output logic [LEN_W-1:0]         pkt_bytes_o,
  output logic                     overrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);

  // Length offered for a source: its fill level, capped at one packet.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] c);
    return (c > MAX_LEN) ? MAX_LEN : c;
  endfunction

  // Saturating byte counter increment.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (c == {LEN_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       src_q, src_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             cork_q, cork_d;
  logic [LEN_W-1:0] txlen_q, txlen_d;
  logic             ovr_q, ovr_d;
  logic [2:0]       pkt_src_q, pkt_src_d;
  logic [LEN_W-1:0] pkt_bytes_q, pkt_bytes_d;
  logic             pop;

  // Endpoint decode. Scanning from the top index down lets the lowest
  // matching index overwrite, so duplicate mappings resolve to it.
  logic             hit;
  logic [2:0]       dec_sel;
  logic [LEN_W-1:0] dec_cnt;

  always_comb begin
    hit     = 1'b0;
    dec_sel = '0;
    dec_cnt = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (EP_MAP[4*i +: 4] == endpt_i) begin
        hit     = 1'b1;
        dec_sel = 3'(i);
        dec_cnt = src_cnt_i[LEN_W*i +: LEN_W];
      end
    end
  end

  // zlp_req: decoded source is empty but owes the host a zero-length packet.
  logic zlp_req;

`ifdef USB_TX_ZLP_EN
  logic [NUM_SRC-1:0] full_last_q, full_last_d;

  always_comb begin
    zlp_req     = 1'b0;
    full_last_d = full_last_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (hit && (dec_sel == 3'(i))) begin
        zlp_req = (dec_cnt == '0) && full_last_q[i];
      end
    end
    // A full-size packet arms the flag; any shorter one (including the ZLP
    // itself) disarms it.
    if (state_q == ST_DONE) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (src_q == 3'(i)) begin
          full_last_d[i] = (cnt_q == MAX_LEN);
        end
      end
    end
    if (usbrst_i) begin
      full_last_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_last_q <= '0;
    end else begin
      full_last_q <= full_last_d;
    end
  end
`else
  assign zlp_req = 1'b0;
`endif

  // Next-state and control.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    cork_d      = cork_q;
    txlen_d     = txlen_q;
    ovr_d       = ovr_q;
    pkt_src_d   = pkt_src_q;
    pkt_bytes_d = pkt_bytes_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cork_d  = !hit || ((dec_cnt == '0) && !zlp_req);
        txlen_d = hit ? clamp_len(dec_cnt) : '0;
        // Start only on an already-published uncorked offer; the latched
        // length is the value the controller has been looking at.
        if (txact_i && hit && !cork_q) begin
          state_d = ST_XFER;
          src_d   = dec_sel;
          len_d   = txlen_q;
          cnt_d   = '0;
          cork_d  = 1'b0;
          txlen_d = txlen_q;
        end
      end

      ST_XFER: begin
        if (txpop_i) begin
          if (cnt_q < len_q) begin
            pop   = 1'b1;
            cnt_d = sat_inc(cnt_q);
          end else begin
            ovr_d = 1'b1;
          end
        end
        // cnt_d already includes a pop taken in the finishing cycle.
        if (!txact_i || txpktfin_i) begin
          state_d     = ST_DONE;
          pkt_src_d   = src_q;
          pkt_bytes_d = cnt_d;
        end
      end

      ST_DONE: begin
        // Withhold an offer for this cycle; IDLE republishes from fresh
        // FIFO levels (and the updated ZLP flag) on the next edge.
        state_d = ST_IDLE;
        cork_d  = 1'b1;
        txlen_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cork_d  = 1'b1;
        txlen_d = '0;
      end
    endcase

    if (usbrst_i) begin
      state_d = ST_IDLE;
      cork_d  = 1'b1;
      txlen_d = '0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      cork_q      <= 1'b1;
      txlen_q     <= '0;
      ovr_q       <= 1'b0;
      pkt_src_q   <= '0;
      pkt_bytes_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cork_q      <= cork_d;
      txlen_q     <= txlen_d;
      ovr_q       <= ovr_d;
      pkt_src_q   <= pkt_src_d;
      pkt_bytes_q <= pkt_bytes_d;
    end
  end

  // Data path and pop routing to the locked source only.
  always_comb begin
    txdat_o   = '0;
    txval_o   = 1'b0;
    src_pop_o = '0;
    if (state_q == ST_XFER) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (src_q == 3'(i)) begin
          txdat_o      = src_dat_i[8*i +: 8];
          txval_o      = src_val_i[i];
          src_pop_o[i] = pop;
        end
      end
    end
  end

  assign txdat_len_o = txlen_q;
  assign txcork_o    = cork_q;
  assign pkt_done_o  = (state_q == ST_DONE);
  assign pkt_src_o   = pkt_src_q;
  assign pkt_bytes_o = pkt_bytes_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_usb_ep_tx_sched.sv
module tb_usb_ep_tx_sched;

  logic        clk;
  logic        reset_i;
  logic        usbrst_i;
  logic [3:0]  endpt_i;
  logic        txact_i;
  logic        txpop_i;
  logic        txpktfin_i;
  logic [7:0]  txdat_o;
  logic        txval_o;
  logic [11:0] txdat_len_o;
  logic        txcork_o;
  logic [15:0] src_dat_i;
  logic [1:0]  src_val_i;
  logic [23:0] src_cnt_i;
  logic [1:0]  src_pop_o;
  logic        pkt_done_o;
  logic [2:0]  pkt_src_o;
  logic [11:0] pkt_bytes_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;

  usb_ep_tx_sched dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .usbrst_i    (usbrst_i),
    .endpt_i     (endpt_i),
    .txact_i     (txact_i),
    .txpop_i     (txpop_i),
    .txpktfin_i  (txpktfin_i),
    .txdat_o     (txdat_o),
    .txval_o     (txval_o),
    .txdat_len_o (txdat_len_o),
    .txcork_o    (txcork_o),
    .src_dat_i   (src_dat_i),
    .src_val_i   (src_val_i),
    .src_cnt_i   (src_cnt_i),
    .src_pop_o   (src_pop_o),
    .pkt_done_o  (pkt_done_o),
    .pkt_src_o   (pkt_src_o),
    .pkt_bytes_o (pkt_bytes_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue n pops; tally cycles whose pop strobe differs from exp_pop.
  task automatic do_pops(input int n, input logic [1:0] exp_pop, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      txpop_i = 1'b1;
      #1;
      if (src_pop_o !== exp_pop) bad++;
      tick();
    end
    txpop_i = 1'b0;
  endtask

  int bad;

  initial begin
    reset_i    = 1'b1;
    usbrst_i   = 1'b0;
    endpt_i    = 4'd0;
    txact_i    = 1'b0;
    txpop_i    = 1'b0;
    txpktfin_i = 1'b0;
    src_dat_i  = {8'h5B, 8'hA5};
    src_val_i  = 2'b11;
    src_cnt_i  = '0;

    tick();
    tick();
    chk("rst_cork", 32'(txcork_o), 32'd1);
    chk("rst_len", 32'(txdat_len_o), 32'd0);
    chk("rst_pop", 32'(src_pop_o), 32'd0);
    chk("rst_done", 32'(pkt_done_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_bytes", 32'(pkt_bytes_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // T1: src0 with 10 bytes on EP2
    src_cnt_i = {12'd0, 12'd10};
    endpt_i   = 4'd2;
    tick();
    chk("t1_len", 32'(txdat_len_o), 32'd10);
    chk("t1_cork", 32'(txcork_o), 32'd0);
    txact_i = 1'b1;
    tick();
    txpop_i = 1'b1;
    #1;
    chk("t1_dat", 32'(txdat_o), 32'hA5);
    chk("t1_val", 32'(txval_o), 32'd1);
    do_pops(10, 2'b01, bad);
    chk("t1_pops", 32'(bad), 32'd0);
    txact_i = 1'b0;
    tick();
    chk("t1_done", 32'(pkt_done_o), 32'd1);
    chk("t1_bytes", 32'(pkt_bytes_o), 32'd10);
    chk("t1_src", 32'(pkt_src_o), 32'd0);
    chk("t1_done_val", 32'(txval_o), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(pkt_done_o), 32'd0);

    // T2: src1 with 1000 bytes on EP3, clamp and overrun
    src_cnt_i = {12'd1000, 12'd0};
    endpt_i   = 4'd3;
    tick();
    chk("t2_len", 32'(txdat_len_o), 32'd512);
    chk("t2_cork", 32'(txcork_o), 32'd0);
    txact_i = 1'b1;
    tick();
    #1;
    chk("t2_dat", 32'(txdat_o), 32'h5B);
    do_pops(512, 2'b10, bad);
    chk("t2_pops", 32'(bad), 32'd0);
    chk("t2_ovr_pre", 32'(overrun_o), 32'd0);
    txpop_i = 1'b1;
    #1;
    chk("t2_pop513", 32'(src_pop_o), 32'd0);
    tick();
    txpop_i = 1'b0;
    chk("t2_ovr", 32'(overrun_o), 32'd1);
    txact_i = 1'b0;
    tick();
    chk("t2_done", 32'(pkt_done_o), 32'd1);
    chk("t2_bytes", 32'(pkt_bytes_o), 32'd512);
    chk("t2_src", 32'(pkt_src_o), 32'd1);
    tick();

    // T3: unmapped endpoint, then mapped but empty
    endpt_i = 4'd5;
    txact_i = 1'b1;
    txpop_i = 1'b1;
    tick();
    tick();
    chk("t3a_cork", 32'(txcork_o), 32'd1);
    chk("t3a_pop", 32'(src_pop_o), 32'd0);
    chk("t3a_done", 32'(pkt_done_o), 32'd0);
    src_cnt_i = {12'd0, 12'd0};
    endpt_i   = 4'd2;
    tick();
    tick();
    chk("t3b_cork", 32'(txcork_o), 32'd1);
    chk("t3b_pop", 32'(src_pop_o), 32'd0);
    chk("t3b_done", 32'(pkt_done_o), 32'd0);
    txact_i = 1'b0;
    txpop_i = 1'b0;
    tick();

    // T4: endpoint switches mid-packet; finish with pop + pktfin together
    src_cnt_i = {12'd50, 12'd20};
    endpt_i   = 4'd2;
    tick();
    tick();
    chk("t4_len", 32'(txdat_len_o), 32'd20);
    txact_i = 1'b1;
    tick();
    do_pops(3, 2'b01, bad);
    chk("t4_pops_a", 32'(bad), 32'd0);
    endpt_i = 4'd3;
    do_pops(3, 2'b01, bad);
    chk("t4_pops_b", 32'(bad), 32'd0);
    chk("t4_len_held", 32'(txdat_len_o), 32'd20);
    chk("t4_cork_held", 32'(txcork_o), 32'd0);
    txpop_i    = 1'b1;
    txpktfin_i = 1'b1;
    #1;
    chk("t4_fin_pop", 32'(src_pop_o), 32'd1);
    tick();
    txpop_i    = 1'b0;
    txpktfin_i = 1'b0;
    txact_i    = 1'b0;
    chk("t4_done", 32'(pkt_done_o), 32'd1);
    chk("t4_bytes", 32'(pkt_bytes_o), 32'd7);
    chk("t4_src", 32'(pkt_src_o), 32'd0);
    tick();
    chk("t4_ovr_sticky", 32'(overrun_o), 32'd1);

    // T5a: async reset after 5 of 20 pops
    src_cnt_i = {12'd0, 12'd20};
    endpt_i   = 4'd2;
    tick();
    tick();
    txact_i = 1'b1;
    tick();
    do_pops(5, 2'b01, bad);
    chk("t5a_pops", 32'(bad), 32'd0);
    txpop_i = 1'b1;
    reset_i = 1'b1;
    #1;
    chk("t5a_cork", 32'(txcork_o), 32'd1);
    chk("t5a_pop", 32'(src_pop_o), 32'd0);
    chk("t5a_ovr", 32'(overrun_o), 32'd0);
    chk("t5a_len", 32'(txdat_len_o), 32'd0);
    chk("t5a_done", 32'(pkt_done_o), 32'd0);
    txpop_i = 1'b0;
    txact_i = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
    chk("t5a_done2", 32'(pkt_done_o), 32'd0);
    tick();
    chk("t5a_done3", 32'(pkt_done_o), 32'd0);

    // Re-arm overrun with a 2-byte packet popped 3 times
    src_cnt_i = {12'd0, 12'd2};
    tick();
    tick();
    txact_i = 1'b1;
    tick();
    do_pops(3, 2'b01, bad);
    chk("ovr_rearm", 32'(overrun_o), 32'd1);
    txact_i = 1'b0;
    tick();
    tick();

    // T5b: usbrst after 5 of 20 pops
    src_cnt_i = {12'd0, 12'd20};
    tick();
    tick();
    txact_i = 1'b1;
    tick();
    do_pops(5, 2'b01, bad);
    chk("t5b_pops", 32'(bad), 32'd0);
    usbrst_i = 1'b1;
    txact_i  = 1'b0;
    tick();
    usbrst_i = 1'b0;
    chk("t5b_cork", 32'(txcork_o), 32'd1);
    chk("t5b_len", 32'(txdat_len_o), 32'd0);
    chk("t5b_ovr", 32'(overrun_o), 32'd0);
    chk("t5b_done", 32'(pkt_done_o), 32'd0);
    chk("t5b_val", 32'(txval_o), 32'd0);
    tick();
    chk("t5b_done2", 32'(pkt_done_o), 32'd0);

    // T6: full-size packet then empty source
    src_cnt_i = {12'd0, 12'd512};
    tick();
    tick();
    chk("t6_len", 32'(txdat_len_o), 32'd512);
    txact_i = 1'b1;
    tick();
    do_pops(512, 2'b01, bad);
    chk("t6_pops", 32'(bad), 32'd0);
    txact_i = 1'b0;
    tick();
    chk("t6_bytes", 32'(pkt_bytes_o), 32'd512);
    tick();
    src_cnt_i = {12'd0, 12'd0};
    tick();
    tick();
`ifdef USB_TX_ZLP_EN
    chk("t6_zlp_cork", 32'(txcork_o), 32'd0);
    chk("t6_zlp_len", 32'(txdat_len_o), 32'd0);
    txact_i = 1'b1;
    tick();
    txpop_i = 1'b1;
    #1;
    chk("t6_zlp_nopop", 32'(src_pop_o), 32'd0);
    txpop_i = 1'b0;
    txact_i = 1'b0;
    tick();
    chk("t6_zlp_done", 32'(pkt_done_o), 32'd1);
    chk("t6_zlp_bytes", 32'(pkt_bytes_o), 32'd0);
    tick();
    tick();
    tick();
    chk("t6_third_cork", 32'(txcork_o), 32'd1);
`else
    chk("t6_second_cork", 32'(txcork_o), 32'd1);
    txact_i = 1'b1;
    tick();
    chk("t6_no_done", 32'(pkt_done_o), 32'd0);
    txact_i = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
